// File: rtl/sinc_ctrl.sv
// Sequencer for a sinc1/sinc2/sinc3 decimation filter bank: generates sample and
// decimation enables, discards settling outputs, and hands results to a consumer.
module sinc_ctrl #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic [1:0]   i_sdiv_sel,
    input  logic [1:0]   i_osr_sel,
    input  logic [1:0]   i_ord_sel,
    input  logic [W-1:0] i_flt_din1,
    input  logic [W-1:0] i_flt_din2,
    input  logic [W-1:0] i_flt_din3,
    input  logic         i_dout_ready,
    output logic         o_fs_en,
    output logic         o_bw_en,
    output logic         o_flt_clr,
    output logic [W-1:0] o_dout,
    output logic         o_dout_valid,
    output logic         o_ovf,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [2:0]   r_sdiv_m1;
    logic [6:0]   r_osr_m1;
    logic [1:0]   r_k;
    logic [2:0]   r_div_cnt;
    logic [6:0]   r_dec_cnt;
    logic [1:0]   r_disc_cnt;
    logic         r_cap;

    logic         r_fs_en;
    logic         r_bw_en;
    logic         r_flt_clr;
    logic [W-1:0] r_dout;
    logic         r_dout_valid;
    logic         r_ovf;
    logic         r_busy;

    logic         w_busy;
    logic         w_restart;
    logic         w_cont;
    logic         w_cap;
    logic         w_cap_run;
    logic         w_xfer;
    logic         w_div_wrap;
    logic         w_dec_wrap;
    logic         w_fs_nxt;
    logic         w_bw_nxt;
    logic [W-1:0] w_sel_din;

    logic         w_flt_clr_nxt;
    logic         w_busy_nxt;
    logic         w_dout_valid_nxt;
    logic         w_ovf_nxt;
    logic [W-1:0] w_dout_nxt;

    function automatic logic [2:0] f_sdiv_m1(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [6:0] f_osr_m1(input logic [1:0] sel);
        case (sel)
            2'b00:   return 7'd15;
            2'b01:   return 7'd31;
            2'b10:   return 7'd63;
            default: return 7'd127;
        endcase
    endfunction

    // stop always wins over start; a start while busy is a full restart
    assign w_busy     = (r_state != ST_IDLE);
    assign w_restart  = i_start & ~i_stop;
    assign w_cont     = w_busy & ~i_start & ~i_stop;
    assign w_cap      = r_cap & w_cont;
    assign w_cap_run  = w_cap & (r_state == ST_RUN);
    assign w_xfer     = r_dout_valid & i_dout_ready;
    assign w_div_wrap = (r_div_cnt == r_sdiv_m1);
    assign w_dec_wrap = (r_dec_cnt == r_osr_m1);
    assign w_fs_nxt   = w_cont & w_div_wrap;
    assign w_bw_nxt   = w_fs_nxt & w_dec_wrap;

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_restart) w_state_nxt = ST_SETTLE;
            end
            default: begin
                if (i_stop)
                    w_state_nxt = ST_IDLE;
                else if (i_start)
                    w_state_nxt = ST_SETTLE;
                else if (r_state == ST_SETTLE && w_cap && r_disc_cnt == r_k - 2'd1)
                    w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        case (r_k)
            2'd2:    w_sel_din = i_flt_din2;
            2'd3:    w_sel_din = i_flt_din3;
            default: w_sel_din = i_flt_din1;
        endcase
        w_flt_clr_nxt    = w_restart;
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_dout_valid_nxt = w_cap_run | (r_dout_valid & ~w_xfer);
        w_dout_nxt       = w_cap_run ? w_sel_din : r_dout;
        // an unconsumed result being overwritten is an overrun
        w_ovf_nxt        = ~w_restart & (r_ovf | (w_cap_run & r_dout_valid & ~i_dout_ready));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sdiv_m1  <= '0;
            r_osr_m1   <= '0;
            r_k        <= 2'd1;
            r_div_cnt  <= '0;
            r_dec_cnt  <= '0;
            r_disc_cnt <= '0;
            r_cap      <= 1'b0;
        end else if (w_restart) begin
            r_sdiv_m1  <= f_sdiv_m1(i_sdiv_sel);
            r_osr_m1   <= f_osr_m1(i_osr_sel);
            r_k        <= (i_ord_sel == 2'b00) ? 2'd1 : i_ord_sel;
            r_div_cnt  <= '0;
            r_dec_cnt  <= '0;
            r_disc_cnt <= '0;
            r_cap      <= 1'b0;
        end else if (w_cont) begin
            r_div_cnt <= w_div_wrap ? 3'd0 : r_div_cnt + 3'd1;
            if (w_fs_nxt)
                r_dec_cnt <= w_dec_wrap ? 7'd0 : r_dec_cnt + 7'd1;
            // filters update on bw_en, so the result is captured one cycle later
            r_cap <= r_bw_en;
            if (w_cap && r_state == ST_SETTLE)
                r_disc_cnt <= r_disc_cnt + 2'd1;
        end else begin
            r_cap <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fs_en      <= 1'b0;
            r_bw_en      <= 1'b0;
            r_flt_clr    <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_fs_en      <= w_fs_nxt;
            r_bw_en      <= w_bw_nxt;
            r_flt_clr    <= w_flt_clr_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_ovf        <= w_ovf_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign o_fs_en      = r_fs_en;
    assign o_bw_en      = r_bw_en;
    assign o_flt_clr    = r_flt_clr;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_ovf        = r_ovf;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_sinc_ctrl.sv
// Bench for sinc_ctrl: a cycle model built from the timing rules (cycle index
// arithmetic) predicts the flags; a scoreboard queue predicts each transferred dout.
module tb_sinc_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [1:0]   sdiv_sel = 2'b00;
    logic [1:0]   osr_sel = 2'b00;
    logic [1:0]   ord_sel = 2'b01;
    logic [W-1:0] din1 = '0;
    logic [W-1:0] din2 = '0;
    logic [W-1:0] din3 = '0;
    logic         dout_ready = 1'b0;
    logic         fs_en, bw_en, flt_clr, dout_valid, ovf, busy;
    logic [W-1:0] dout;

    sinc_ctrl #(.W(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_sdiv_sel   (sdiv_sel),
        .i_osr_sel    (osr_sel),
        .i_ord_sel    (ord_sel),
        .i_flt_din1   (din1),
        .i_flt_din2   (din2),
        .i_flt_din3   (din3),
        .i_dout_ready (dout_ready),
        .o_fs_en      (fs_en),
        .o_bw_en      (bw_en),
        .o_flt_clr    (flt_clr),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_ovf        (ovf),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of the cycle currently in progress.
    bit           m_busy = 0, m_settle = 0, m_clr = 0, m_valid = 0, m_ovf = 0;
    int           m_c = 0, m_sdiv = 1, m_osr = 16, m_k = 1, m_disc = 0;
    logic [W-1:0] sb[$];

    bit           e_fs, e_bw, cap, xfer, pre_valid;
    logic [W-1:0] exp_v, cap_v;

    // Outputs and inputs are both stable at the falling edge.
    always @(negedge clk) begin
        e_fs = m_busy && m_c > 0 && (m_c % m_sdiv) == 0;
        e_bw = e_fs && ((m_c / m_sdiv) % m_osr) == 0;
        check("flags{clr,fs,bw,busy,valid,ovf}",
              {26'd0, flt_clr, fs_en, bw_en, busy, dout_valid, ovf},
              {26'd0, m_clr, e_fs, e_bw, m_busy, m_valid, m_ovf});

        xfer = m_valid && dout_ready;
        if (xfer) begin
            exp_v = (sb.size() > 0) ? sb.pop_front() : 'x;
            check("dout", {16'd0, dout}, {16'd0, exp_v});
        end

        cap = m_busy && m_c > 1 && ((m_c - 1) % (m_sdiv * m_osr)) == 0;
        pre_valid = m_valid;
        m_clr = 0;
        if (rst) begin
            m_busy = 0; m_settle = 0; m_valid = 0; m_ovf = 0;
            m_c = 0; m_disc = 0;
            sb.delete();
        end else if (stop) begin
            m_busy = 0;
            if (xfer) m_valid = 0;
        end else if (start) begin
            m_sdiv   = 1 << sdiv_sel;
            m_osr    = 16 << osr_sel;
            m_k      = (ord_sel == 2'b00) ? 1 : int'(ord_sel);
            m_busy   = 1; m_settle = 1; m_c = 0; m_disc = 0;
            m_ovf    = 0; m_clr = 1;
            if (xfer) m_valid = 0;
        end else begin
            if (m_busy) m_c++;
            if (xfer) m_valid = 0;
            if (cap && m_settle) begin
                m_disc++;
                if (m_disc == m_k) m_settle = 0;
            end else if (cap) begin
                if (pre_valid && !dout_ready) begin
                    m_ovf = 1;
                    if (sb.size() > 0) void'(sb.pop_back());
                end
                case (m_k)
                    1:       cap_v = din1;
                    2:       cap_v = din2;
                    default: cap_v = din3;
                endcase
                sb.push_back(cap_v);
                m_valid = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        din1 = 16'($urandom);
        din2 = 16'($urandom);
        din3 = 16'($urandom);
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic go(input logic [1:0] s, input logic [1:0] o, input logic [1:0] k);
        sdiv_sel = s; osr_sel = o; ord_sel = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        check("dout_after_reset", {16'd0, dout}, 32'd0);
        cycles(2);

        // SDIV=1, OSR=16, K=1, consumer always ready
        dout_ready = 1'b1;
        go(2'b00, 2'b00, 2'b01);
        cycles(40);
        halt();
        cycles(3);

        // SDIV=4, OSR=16, K=3; config inputs wiggle while busy
        go(2'b10, 2'b00, 2'b11);
        cycles(5);
        sdiv_sel = 2'b00; osr_sel = 2'b11; ord_sel = 2'b01;
        cycles(257);
        halt();
        cycles(3);

        // ord_sel=00 acts as K=1; overrun, then restart with a pending result
        dout_ready = 1'b0;
        go(2'b00, 2'b00, 2'b00);
        cycles(55);
        go(2'b00, 2'b00, 2'b01);
        cycles(10);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        cycles(38);
        // ready rises exactly in the capture cycle c49
        dout_ready = 1'b1;
        cycles(11);
        halt();
        cycles(3);

        // start and stop together in IDLE: nothing starts
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        cycles(3);

        // stop during SETTLE, then restart with a new configuration
        go(2'b01, 2'b01, 2'b10);
        cycles(20);
        halt();
        cycles(4);
        go(2'b11, 2'b00, 2'b10);
        cycles(390);
        halt();
        cycles(3);

        // reset mid-run with a pending result
        dout_ready = 1'b0;
        go(2'b00, 2'b00, 2'b01);
        cycles(40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("dout_after_mid_reset", {16'd0, dout}, 32'd0);
        cycles(3);
        dout_ready = 1'b1;
        cycles(2);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sinc_ctrl.md
SINC_CTRL -- requirements
Module: sinc_ctrl

Interface
REQ-001 Parameter W, default 16, width of filter result buses and dout.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  single-cycle pulse: latch config, clear filters, begin conversion.
REQ-005 stop  in  1  single-cycle pulse: end conversion.
REQ-006 sdiv_sel  in  2  sample divider SDIV: 00=1, 01=2, 10=4, 11=8.
REQ-007 osr_sel  in  2  oversampling ratio OSR: 00=16, 01=32, 10=64, 11=128.
REQ-008 ord_sel  in  2  filter order K: 01=sinc1, 10=sinc2, 11=sinc3, 00 treated as 01.
REQ-009 flt_din1, flt_din2, flt_din3  in  W each  results of the sinc1/sinc2/sinc3 filters.
REQ-010 fs_en  out  1  modulator sample enable to filters.
REQ-011 bw_en  out  1  decimation enable to filters.
REQ-012 flt_clr  out  1  filter clear pulse.
REQ-013 dout  out  W  selected decimated result.
REQ-014 dout_valid  out  1  dout holds an unconsumed result.
REQ-015 dout_ready  in  1  consumer accepts dout.
REQ-016 ovf  out  1  sticky overrun flag.
REQ-017 busy  out  1  high in SETTLE or RUN.

Function
REQ-018 States IDLE, SETTLE, RUN; all outputs registered.
REQ-019 IDLE + start -> SETTLE; SDIV, OSR and K latched from inputs on that edge; ovf cleared; sample and decimation counters zeroed.
REQ-020 First SETTLE cycle (c0): flt_clr=1, fs_en=0; flt_clr=0 in all other cycles.
REQ-021 From c0, fs_en high exactly once every SDIV cycles, first at cycle cSDIV; SDIV=1 gives fs_en every cycle from c1.
REQ-022 bw_en high coincident with every OSR-th fs_en, i.e. at cycle c(SDIV*OSR*n), n>=1; counters wrap silently.
REQ-023 Capture occurs in the cycle after each bw_en (filters update on bw_en).
REQ-024 SETTLE discards the first K captures; at the K-th discarded capture the state -> RUN.
REQ-025 Each RUN capture loads dout with flt_din<K> and sets dout_valid on the ending edge (visible next cycle).
REQ-026 Transfer occurs when dout_valid & dout_ready; dout_valid clears next cycle unless a capture coincides.
REQ-027 Capture + transfer in same cycle: new data loaded, dout_valid stays 1, no ovf.
REQ-028 Capture while dout_valid=1 and dout_ready=0: dout overwritten, dout_valid stays 1, ovf set until next start or rst.
REQ-029 stop in SETTLE/RUN -> IDLE next edge; fs_en, bw_en, busy low from next cycle; a pending dout_valid persists until transferred.
REQ-030 start while busy restarts exactly as from IDLE (re-latch, flt_clr, counters zeroed); pending dout_valid is kept.
REQ-031 start and stop in the same cycle: stop wins.
REQ-032 Config input changes while busy have no effect until the next start.

Reset
REQ-033 rst has priority over all inputs: state IDLE, all counters 0, fs_en=bw_en=flt_clr=0, dout=0, dout_valid=0, ovf=0, busy=0.
REQ-034 rst asserted mid-conversion aborts immediately on that edge; any pending result is discarded.

Verification
REQ-035 SDIV=1, OSR=16, K=1, dout_ready=1: flt_clr at c0, bw_en at c16,c32, dout_valid high in c34 only, dout=flt_din1.
REQ-036 SDIV=4, OSR=16, K=3: fs_en period 4, bw_en at c64,c128,c192,c256; first dout_valid in c258 with flt_din3.
REQ-037 K=1, dout_ready=0 across two RUN captures: dout holds second value, ovf=1; next start clears ovf.
REQ-038 dout_ready rises exactly in a capture cycle: dout_valid stays continuously high, new value visible, ovf=0.
REQ-039 stop during SETTLE, then start with different SDIV/OSR: flt_clr pulses again, timing follows new config from c0.
REQ-040 rst pulse at c40 of a run with dout_valid=1: next cycle all outputs 0 and state IDLE.
